paint_brush_ctrl: RTL and testbench

Converts PS/2 mouse position and button state into a stream of single-pixel framebuffer writes. Stamps a square brush centred on the cursor while drawing, and can sweep the whole screen to clear it. Sits between the `ps2` mouse decoder and `VGA_framebuffer`, replacing the fixed one-pixel, always-write path. Generalises that path in brush size, colour width, screen geometry and mode (draw / erase / clear).

---
 rtl/paint_brush_ctrl_pkg.sv | 19 +
 rtl/paint_brush_ctrl_if.sv | 34 +++
 rtl/paint_brush_ctrl_xy_scan.sv | 51 +++++
 rtl/paint_brush_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_paint_brush_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/paint_brush_ctrl_pkg.sv
// paint_pkg: shared types and constants for the paint brush controller.
//   state_t       - controller mode (IDLE, STAMP, CLEAR)
//   BG_COLOR      - colour written by erase and by screen clear
//   brush_radius  - half-width R of an odd square brush of side BRUSH
package paint_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STAMP = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam int BG_COLOR = 0;

   function automatic int brush_radius(input int brush);
      return (brush - 1) / 2;
   endfunction

endpackage

// File: rtl/paint_brush_ctrl_if.sv
// paint_brush_ctrl_if: mouse-side inputs and framebuffer-side write port of
// the paint brush controller.
//   mouse_x/mouse_y, button_left/button_right, color_in, clear_req : to controller
//   fb_x/fb_y/fb_color/fb_write : pixel write strobe to the framebuffer
//   busy, clear_done            : status from controller
// master = stimulus / mouse side, slave = the controller.
interface paint_brush_ctrl_if #(
   parameter int X_W     = 11,
   parameter int Y_W     = 11,
   parameter int COLOR_W = 1
);
   logic [X_W-1:0]     mouse_x;
   logic [Y_W-1:0]     mouse_y;
   logic               button_left;
   logic               button_right;
   logic [COLOR_W-1:0] color_in;
   logic               clear_req;
   logic [X_W-1:0]     fb_x;
   logic [Y_W-1:0]     fb_y;
   logic [COLOR_W-1:0] fb_color;
   logic               fb_write;
   logic               busy;
   logic               clear_done;

   modport master (
      output mouse_x, mouse_y, button_left, button_right, color_in, clear_req,
      input  fb_x, fb_y, fb_color, fb_write, busy, clear_done
   );

   modport slave (
      input  mouse_x, mouse_y, button_left, button_right, color_in, clear_req,
      output fb_x, fb_y, fb_color, fb_write, busy, clear_done
   );
endinterface

// File: rtl/paint_brush_ctrl_xy_scan.sv
// xy_scan: nested x/y raster counter over signed ranges.
//   clk, rst       - clock, synchronous active-high reset
//   load           - restart at (x_start, y_start) and capture the ranges
//   step           - advance x; on x_end wrap x to x_start and advance y
//   x, y           - current position (signed)
//   last           - current position is (x_end, y_end)
module xy_scan #(
   parameter int X_W = 11,
   parameter int Y_W = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                step,
   input  logic signed [X_W:0] x_start,
   input  logic signed [X_W:0] x_end,
   input  logic signed [Y_W:0] y_start,
   input  logic signed [Y_W:0] y_end,
   output logic signed [X_W:0] x,
   output logic signed [Y_W:0] y,
   output logic                last
);
   logic signed [X_W:0] x_lo;
   logic signed [X_W:0] x_hi;
   logic signed [Y_W:0] y_hi;

   always_ff @(posedge clk) begin
      if (rst) begin
         x    <= '0;
         y    <= '0;
         x_lo <= '0;
         x_hi <= '0;
         y_hi <= '0;
      end else if (load) begin
         x    <= x_start;
         y    <= y_start;
         x_lo <= x_start;
         x_hi <= x_end;
         y_hi <= y_end;
      end else if (step) begin
         if (x == x_hi) begin
            x <= x_lo;
            y <= y + (Y_W+1)'(1);
         end else begin
            x <= x + (X_W+1)'(1);
         end
      end
   end

   assign last = (x == x_hi) && (y == y_hi);
endmodule

// File: rtl/paint_brush_ctrl.sv
// paint_brush_ctrl: turns mouse position/buttons into single-pixel
// framebuffer writes, stamping a BRUSH x BRUSH square around the cursor, and
// sweeps the whole screen with colour 0 on clear_req.
//   CLOCK_50  - clock
//   reset     - synchronous active-high reset
//   bus       - slave side of paint_brush_ctrl_if (mouse in, fb writes out)
// Build option: define PAINT_ERASE_EN to let button_right stamp colour 0;
// without it button_right is ignored.
module paint_brush_ctrl
   import paint_pkg::*;
#(
   parameter int X_W      = 11,
   parameter int Y_W      = 11,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int BRUSH    = 3,
   parameter int COLOR_W  = 1
) (
   input logic               CLOCK_50,
   input logic               reset,
   paint_brush_ctrl_if.slave bus
);
   localparam int R = brush_radius(BRUSH);
   localparam logic signed [X_W:0] DX_LO = (X_W+1)'(-R);
   localparam logic signed [X_W:0] DX_HI = (X_W+1)'(R);
   localparam logic signed [Y_W:0] DY_LO = (Y_W+1)'(-R);
   localparam logic signed [Y_W:0] DY_HI = (Y_W+1)'(R);
   localparam logic signed [X_W:0] SX_HI = (X_W+1)'(SCREEN_W - 1);
   localparam logic signed [Y_W:0] SY_HI = (Y_W+1)'(SCREEN_H - 1);
   localparam logic signed [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
   localparam logic signed [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

   state_t              state, state_nxt;
   logic                pend;
   logic                btn_q;
   logic                last_vld;
   logic [X_W-1:0]      last_x, cx;
   logic [Y_W-1:0]      last_y, cy;
   logic [COLOR_W-1:0]  col;
   logic                act, trig, moved;
   logic [COLOR_W-1:0]  act_col;

   logic                sc_load, sc_step, sc_last;
   logic signed [X_W:0] ld_xs, ld_xe, sc_x, px;
   logic signed [Y_W:0] ld_ys, ld_ye, sc_y, py;
   logic                in_range;

   logic [X_W-1:0]      fb_x_r;
   logic [Y_W-1:0]      fb_y_r;
   logic [COLOR_W-1:0]  fb_color_r;
   logic                fb_write_r, busy_r, done_r, in_clr;

   xy_scan #(.X_W(X_W), .Y_W(Y_W)) u_scan (
      .clk(CLOCK_50), .rst(reset), .load(sc_load), .step(sc_step),
      .x_start(ld_xs), .x_end(ld_xe), .y_start(ld_ys), .y_end(ld_ye),
      .x(sc_x), .y(sc_y), .last(sc_last)
   );

`ifdef PAINT_ERASE_EN
   // Left wins when both buttons are down.
   assign act     = bus.button_left | bus.button_right;
   assign act_col = bus.button_left ? bus.color_in : COLOR_W'(BG_COLOR);
`else
   logic right_unused;
   assign right_unused = bus.button_right;
   assign act          = bus.button_left;
   assign act_col      = bus.color_in;
`endif

   // An invalid record (after reset or clear) counts as "moved".
   assign moved = !last_vld || (bus.mouse_x != last_x) || (bus.mouse_y != last_y);
   assign trig  = act && (!btn_q || moved);

   // Offsets are added in X_W+1/Y_W+1 signed; anything negative or beyond the
   // screen is clipped, so an overflow past the top of the range also clips.
   assign px       = $signed({1'b0, cx}) + sc_x;
   assign py       = $signed({1'b0, cy}) + sc_y;
   assign in_range = !px[X_W] && !py[Y_W] && (px < X_LIM) && (py < Y_LIM);

   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sc_load   = 1'b0;
      sc_step   = 1'b0;
      ld_xs     = DX_LO;
      ld_xe     = DX_HI;
      ld_ys     = DY_LO;
      ld_ye     = DY_HI;
      case (state)
         IDLE: begin
            if (pend || bus.clear_req) begin
               state_nxt = CLEAR;
               sc_load   = 1'b1;
               ld_xs     = '0;
               ld_xe     = SX_HI;
               ld_ys     = '0;
               ld_ye     = SY_HI;
            end else if (trig) begin
               state_nxt = STAMP;
               sc_load   = 1'b1;
            end
         end
         STAMP, CLEAR: begin
            if (sc_last) state_nxt = IDLE;
            else         sc_step   = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control: pending clear, button history, last-stamped record.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pend     <= 1'b0;
         btn_q    <= 1'b0;
         last_vld <= 1'b0;
      end else begin
         btn_q <= act;
         if (state == IDLE && state_nxt == CLEAR)
            pend <= 1'b0;
         else if (state != IDLE && bus.clear_req)
            pend <= 1'b1;
         if (state == STAMP && sc_last)
            last_vld <= 1'b1;
         else if (state == CLEAR && sc_last)
            last_vld <= 1'b0;
      end
   end

   // Stamp centre/colour and last centre carry no reset.
   always_ff @(posedge CLOCK_50) begin
      if (state == IDLE && state_nxt == STAMP) begin
         cx  <= bus.mouse_x;
         cy  <= bus.mouse_y;
         col <= act_col;
      end
      if (state == STAMP && sc_last) begin
         last_x <= cx;
         last_y <= cy;
      end
   end

   // Registered write port; busy/clear_done trail the state by one cycle so
   // they line up with the writes they describe.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         fb_x_r     <= '0;
         fb_y_r     <= '0;
         fb_color_r <= '0;
         fb_write_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         in_clr     <= 1'b0;
      end else begin
         fb_write_r <= 1'b0;
         busy_r     <= (state != IDLE);
         in_clr     <= (state == CLEAR);
         done_r     <= in_clr && (state == IDLE);
         if (state == STAMP && in_range) begin
            fb_x_r     <= px[X_W-1:0];
            fb_y_r     <= py[Y_W-1:0];
            fb_color_r <= col;
            fb_write_r <= 1'b1;
         end else if (state == CLEAR) begin
            fb_x_r     <= sc_x[X_W-1:0];
            fb_y_r     <= sc_y[Y_W-1:0];
            fb_color_r <= COLOR_W'(BG_COLOR);
            fb_write_r <= 1'b1;
         end
      end
   end

   assign bus.fb_x       = fb_x_r;
   assign bus.fb_y       = fb_y_r;
   assign bus.fb_color   = fb_color_r;
   assign bus.fb_write   = fb_write_r;
   assign bus.busy       = busy_r;
   assign bus.clear_done = done_r;
endmodule

// File: tb/tb_paint_brush_ctrl.sv
// tb_paint_brush_ctrl: directed bench for paint_brush_ctrl. Instance a uses a
// 640x480 screen for stamping; instance b uses an 8x4 screen for clear.
module tb_paint_brush_ctrl;
   localparam int XW = 11;
   localparam int YW = 11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   paint_brush_ctrl_if #(.X_W(XW), .Y_W(YW), .COLOR_W(1)) bus_a ();
   paint_brush_ctrl_if #(.X_W(XW), .Y_W(YW), .COLOR_W(1)) bus_b ();

   paint_brush_ctrl #(.X_W(XW), .Y_W(YW), .SCREEN_W(640), .SCREEN_H(480),
                      .BRUSH(3), .COLOR_W(1))
      dut_a (.CLOCK_50(clk), .reset(rst), .bus(bus_a));

   paint_brush_ctrl #(.X_W(XW), .Y_W(YW), .SCREEN_W(8), .SCREEN_H(4),
                      .BRUSH(3), .COLOR_W(1))
      dut_b (.CLOCK_50(clk), .reset(rst), .bus(bus_b));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [22:0] pix(input int x, input int y, input logic c);
      return {11'(x), 11'(y), c};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Write monitors (only ever appended / incremented here).
   logic [22:0] wq_a[$];
   int busy_a_n = 0, nowr_a_n = 0;
   int b_c0 = 0, b_c1 = 0, b_order_bad = 0, b_done = 0;
   logic [21:0] b_first_c0 = '1, b_last_c0 = '1;
   logic b_done_busy = 1'b1;

   always @(negedge clk) begin
      if (bus_a.fb_write) wq_a.push_back({bus_a.fb_x, bus_a.fb_y, bus_a.fb_color});
      if (bus_a.busy) busy_a_n++;
      if (bus_a.busy && !bus_a.fb_write) nowr_a_n++;
      if (bus_b.fb_write) begin
         if (bus_b.fb_color == 1'b0) begin
            if (b_c0 == 0) b_first_c0 = {bus_b.fb_x, bus_b.fb_y};
            b_last_c0 = {bus_b.fb_x, bus_b.fb_y};
            b_c0++;
         end else begin
            b_c1++;
            if (b_c0 != 0) b_order_bad++;
         end
      end
      if (bus_b.clear_done) begin
         b_done++;
         b_done_busy = bus_b.busy;
      end
   end

   function automatic logic [22:0] wq_at(input int i);
      return (i < wq_a.size()) ? wq_a[i] : 23'h7fffff;
   endfunction

   task automatic expect_stamp(input string tag, input int base, input int cx,
                               input int cy, input logic c);
      int k = 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++) begin
            check($sformatf("%s_w%0d", tag, k), 32'(wq_at(base + k)), 32'(pix(cx + dx, cy + dy, c)));
            k++;
         end
   endtask

   initial begin
      int base, bcnt, ncnt, zc;
      {bus_a.mouse_x, bus_a.mouse_y, bus_a.button_left, bus_a.button_right} = '0;
      {bus_a.color_in, bus_a.clear_req} = '0;
      {bus_b.mouse_x, bus_b.mouse_y, bus_b.button_left, bus_b.button_right} = '0;
      {bus_b.color_in, bus_b.clear_req} = '0;

      // Reset
      rst = 1'b1;
      tick(2);
      check("rst_fb_x", 32'(bus_a.fb_x), 0);
      check("rst_fb_y", 32'(bus_a.fb_y), 0);
      check("rst_fb_color", 32'(bus_a.fb_color), 0);
      check("rst_fb_write", 32'(bus_a.fb_write), 0);
      check("rst_busy", 32'(bus_a.busy), 0);
      check("rst_clear_done", 32'(bus_b.clear_done), 0);
      rst = 1'b0;
      base = wq_a.size();
      tick(10);
      check("idle_no_writes", 32'(wq_a.size() - base), 0);

      // Centre stamp at (100,50), colour 1
      base = wq_a.size();
      bcnt = busy_a_n;
      bus_a.mouse_x = 11'd100; bus_a.mouse_y = 11'd50;
      bus_a.color_in = 1'b1;   bus_a.button_left = 1'b1;
      tick(1);
      check("lat_t_write", 32'(bus_a.fb_write), 0);
      check("lat_t_busy", 32'(bus_a.busy), 0);
      tick(1);
      check("lat_t1_write", 32'(bus_a.fb_write), 1);
      check("lat_t1_xy", {bus_a.fb_x, bus_a.fb_y}, {11'd99, 11'd49});
      check("lat_t1_busy", 32'(bus_a.busy), 1);
      tick(8);
      check("lat_t9_xy", {bus_a.fb_write, bus_a.fb_x, bus_a.fb_y}, {1'b1, 11'd101, 11'd51});
      tick(1);
      check("lat_t10_busy", 32'(bus_a.busy), 0);
      check("lat_t10_write", 32'(bus_a.fb_write), 0);
      check("hold_fb_x", 32'(bus_a.fb_x), 101);
      check("centre_count", 32'(wq_a.size() - base), 9);
      check("centre_busy_cycles", 32'(busy_a_n - bcnt), 9);
      expect_stamp("centre", base, 100, 50, 1'b1);

      // Held stationary: no further stamps
      base = wq_a.size();
      tick(50);
      check("held_no_restamp", 32'(wq_a.size() - base), 0);

      // Move while held
      base = wq_a.size();
      bus_a.mouse_x = 11'd101;
      tick(15);
      check("move_count", 32'(wq_a.size() - base), 9);
      expect_stamp("move", base, 101, 50, 1'b1);
      bus_a.button_left = 1'b0;
      tick(3);

      // Corner clip at (0,0)
      base = wq_a.size();
      ncnt = nowr_a_n;
      bus_a.mouse_x = 11'd0; bus_a.mouse_y = 11'd0; bus_a.button_left = 1'b1;
      tick(15);
      check("corner_count", 32'(wq_a.size() - base), 4);
      check("corner_w0", 32'(wq_at(base + 0)), 32'(pix(0, 0, 1'b1)));
      check("corner_w1", 32'(wq_at(base + 1)), 32'(pix(1, 0, 1'b1)));
      check("corner_w2", 32'(wq_at(base + 2)), 32'(pix(0, 1, 1'b1)));
      check("corner_w3", 32'(wq_at(base + 3)), 32'(pix(1, 1, 1'b1)));
      check("corner_clipped_cycles", 32'(nowr_a_n - ncnt), 5);
      bus_a.button_left = 1'b0;
      tick(3);

      // Clear on the 8x4 instance, two requests during a stamp at (3,2)
      bus_b.mouse_x = 11'd3; bus_b.mouse_y = 11'd2;
      bus_b.color_in = 1'b1; bus_b.button_left = 1'b1;
      tick(1);
      bus_b.button_left = 1'b0;
      tick(1);
      bus_b.clear_req = 1'b1; tick(1); bus_b.clear_req = 1'b0;
      tick(2);
      bus_b.clear_req = 1'b1; tick(1); bus_b.clear_req = 1'b0;
      tick(60);
      check("clr_stamp_writes", 32'(b_c1), 9);
      check("clr_writes", 32'(b_c0), 32);
      check("clr_after_stamp", 32'(b_order_bad), 0);
      check("clr_first_xy", 32'(b_first_c0), {11'd0, 11'd0});
      check("clr_last_xy", 32'(b_last_c0), {11'd7, 11'd3});
      check("clr_done_pulses", 32'(b_done), 1);
      check("clr_done_busy_low", 32'(b_done_busy), 0);

      // Erase with the right button at (10,10)
      base = wq_a.size();
      bus_a.mouse_x = 11'd10; bus_a.mouse_y = 11'd10;
      bus_a.color_in = 1'b1; bus_a.button_right = 1'b1;
      tick(15);
      zc = 0;
      for (int i = base; i < wq_a.size(); i++) if (wq_a[i][0] == 1'b0) zc++;
`ifdef PAINT_ERASE_EN
      check("erase_count", 32'(wq_a.size() - base), 9);
      check("erase_zero_colour", 32'(zc), 9);
      expect_stamp("erase", base, 10, 10, 1'b0);
`else
      check("erase_ignored", 32'(wq_a.size() - base), 0);
      check("erase_zero_colour", 32'(zc), 0);
`endif
      bus_a.button_right = 1'b0;
      tick(3);

      // Reset at write 5 of a stamp at (200,100); a pending clear is dropped
      base = wq_a.size();
      bus_a.mouse_x = 11'd200; bus_a.mouse_y = 11'd100; bus_a.button_left = 1'b1;
      tick(1);
      tick(1);
      bus_a.clear_req = 1'b1; tick(1); bus_a.clear_req = 1'b0;
      tick(3);
      check("abort_w5", {bus_a.fb_write, bus_a.fb_x, bus_a.fb_y}, {1'b1, 11'd200, 11'd100});
      rst = 1'b1;
      bus_a.button_left = 1'b0;
      tick(1);
      check("abort_write_low", 32'(bus_a.fb_write), 0);
      check("abort_busy_low", 32'(bus_a.busy), 0);
      rst = 1'b0;
      tick(10);
      check("abort_total_writes", 32'(wq_a.size() - base), 5);
      check("abort_idle_busy", 32'(bus_a.busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
